// File: rtl/regfile_param_if.sv
// Register file bus: two read ports, one write port, clear-sweep request.
// Master drives selectors/data, slave (the register file) returns reads and busy.
interface regfile_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] selector_a;
    logic [ADDR_W-1:0] selector_b;
    logic [ADDR_W-1:0] selector_e;
    logic              write_bit;
    logic [DATA_W-1:0] data_in;
    logic              clear_start;
    logic [DATA_W-1:0] data_out_a;
    logic [DATA_W-1:0] data_out_b;
    logic              busy;

    modport master (
        output selector_a, selector_b, selector_e,
        output write_bit, data_in, clear_start,
        input  data_out_a, data_out_b, busy
    );

    modport slave (
        input  selector_a, selector_b, selector_e,
        input  write_bit, data_in, clear_start,
        output data_out_a, data_out_b, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parameterised register file with a DEPTH-cycle sweep-clear controller.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input logic             CLK,
    input logic             RST,
    regfile_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                IDLE: begin
                    // A clear request wins over a same-edge write
                    if (bus.clear_start) begin
                        r_ptr <= '0;
                    end else if (bus.write_bit) begin
                        r_mem[bus.selector_e] <= bus.data_in;
                    end
                end
                CLEAR: begin
                    r_mem[r_ptr] <= '0;
                    r_ptr        <= r_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.clear_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (r_ptr == LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (r_state == CLEAR);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = (r_state == IDLE) && bus.write_bit
                && !bus.clear_start && !RST;

    assign bus.data_out_a = (w_fwd && (bus.selector_e == bus.selector_a))
                          ? bus.data_in : r_mem[bus.selector_a];
    assign bus.data_out_b = (w_fwd && (bus.selector_e == bus.selector_b))
                          ? bus.data_in : r_mem[bus.selector_b];
`else
    assign bus.data_out_a = r_mem[bus.selector_a];
    assign bus.data_out_b = r_mem[bus.selector_b];
`endif
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 8: width in bits of every register and data port.
REQ-002 Parameter ADDR_W, default 2: selector width; register count DEPTH = 2**ADDR_W.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 selector_a  input  ADDR_W  read-port A register index.
REQ-006 selector_b  input  ADDR_W  read-port B register index.
REQ-007 write_bit  input  1  write enable for the write port.
REQ-008 selector_e  input  ADDR_W  write-port register index.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 clear_start  input  1  request to sweep-clear all registers.
REQ-011 data_out_a  output  DATA_W  contents of register selector_a.
REQ-012 data_out_b  output  DATA_W  contents of register selector_b.
REQ-013 busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 Reads SHALL be combinational: data_out_a/b reflect the selected register in the same cycle, no clock latency.
REQ-015 In IDLE with write_bit=1 and clear_start=0, register[selector_e] SHALL take data_in at the rising edge; visible on reads right after that edge.
REQ-016 Controller SHALL have two states: IDLE and CLEAR, plus an ADDR_W-bit sweep pointer.
REQ-017 IDLE with clear_start=1 at an edge: -> CLEAR, pointer=0, any concurrent write SHALL be dropped (clear has priority).
REQ-018 In CLEAR, each edge SHALL zero register[pointer] and increment pointer; the edge that zeroes register DEPTH-1 SHALL return to IDLE.
REQ-019 busy SHALL be 1 exactly while state=CLEAR, i.e. DEPTH consecutive cycles per sweep.
REQ-020 In CLEAR, write_bit and clear_start SHALL be ignored; no register other than register[pointer] changes.
REQ-021 Pointer wrap-around SHALL not occur: sweep ends at DEPTH-1, pointer reloads 0 on next start.
REQ-022 Reads during CLEAR SHALL return current stored contents (already-cleared entries read 0).
REQ-023 Two read ports selecting the same register SHALL return identical values.

Reset
REQ-024 RST=1 at an edge SHALL zero all DEPTH registers, set state IDLE, pointer 0, busy 0; RST overrides write and clear.
REQ-025 RST asserted mid-sweep SHALL abort the sweep; all registers read 0 after that edge.
REQ-026 Outputs after reset: data_out_a=0, data_out_b=0, busy=0.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined: when state=IDLE, write_bit=1, clear_start=0, RST=0 and selector_e equals selector_a (resp. selector_b), data_out_a (resp. data_out_b) SHALL equal data_in combinationally in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN: reads SHALL return the old stored value until the write edge; no forwarding logic present.

Verification
REQ-030 Defaults; RST 1 cycle; write_bit=1, selector_e=0, data_in=7, selector_a=0, selector_b=1, one edge -> data_out_a=7, data_out_b=0.
REQ-031 Fill regs 0..3 with 0x11,0x22,0x33,0x44; pulse clear_start one cycle -> busy high exactly 4 cycles, after 1st sweep edge reg0=0 and reg1=0x22, afterwards all read 0.
REQ-032 During sweep, write_bit=1, selector_e=3, data_in=0xAA -> ignored; reg3 reads 0 after sweep, busy unaffected.
REQ-033 Sweep running at pointer=2 with regs prior 0x55; assert RST one edge -> busy=0, all regs 0, next write of 0x66 to reg2 succeeds.
REQ-034 Same cycle write_bit=1, selector_e=2, data_in=0x5A, selector_a=2, reg2 held 0x10: before edge data_out_a=0x5A with REGFILE_BYPASS_EN, 0x10 without; both 0x5A after edge.
REQ-035 DATA_W=16, ADDR_W=3: write 0xBEEF to reg7, read on both ports -> 0xBEEF; clear sweep -> busy high 8 cycles.
